// File: rtl/mips_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_seq
//  Purpose  : Sequential MIPS main controller. Decodes opcode, REGIMM rt and
//             function fields, sequences each instruction through FETCH and
//             EXEC, tracks a background multiply/divide busy count with
//             HI/LO hazard stalls, branch delay slots and halt-on-JR-to-zero.
//  Revision : 1.0  initial release
// ============================================================================
module mips_ctrl_seq #(
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 34,
   parameter int CNT_W    = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_enable,
   input  logic       instr_valid,
   input  logic [5:0] insop,
   input  logic [4:0] branchfield,
   input  logic [5:0] func,
   input  logic       branch_taken,
   input  logic       jr_target_zero,
   output logic       regdst,
   output logic       jump,
   output logic       branch,
   output logic       memread,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrc,
   output logic [1:0] aluop,
   output logic       link,
   output logic       hilo_write,
   output logic       muldiv_start,
   output logic       muldiv_busy,
   output logic       stall,
   output logic       pc_write,
   output logic       delay_slot,
   output logic       pc_sel_target,
   output logic       illegal,
   output logic       active
);

   localparam logic [CNT_W-1:0] c_mult_lat = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] c_div_lat  = CNT_W'(DIV_LAT);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_EXEC   = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Decoded control bundle; the is_* flags are internal sequencing hints.
   typedef struct packed {
      logic       regdst;
      logic       jump;
      logic       branch;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrc;
      logic [1:0] aluop;
      logic       link;
      logic       hilo_write;
      logic       muldiv_start;
      logic       illegal;
      logic       is_mul;
      logic       is_div;
      logic       is_jr;
   } ctrl_t;

   state_t           r_state;
   state_t           w_next;
   ctrl_t            w_dec;
   ctrl_t            r_ctrl;
   logic             w_hazard;
   logic             w_busy;
   logic             w_advance;
   logic [CNT_W-1:0] r_busy_cnt;
   logic             r_slot_pending;
   logic             r_target_pending;
   logic             r_halt_pending;

   assign w_busy    = (r_busy_cnt != '0);
   assign w_advance = (r_state == ST_FETCH) && instr_valid && clk_enable
                      && !(w_hazard && w_busy);

   // Instruction decode: opcode, then REGIMM rt or SPECIAL func.
   always_comb begin
      w_dec    = '0;
      w_hazard = 1'b0;
      case (insop)
         6'b000000: begin
            case (func)
               6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
               6'b000111, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
               6'b100110, 6'b101010, 6'b101011: begin
                  w_dec.regdst   = 1'b1;
                  w_dec.regwrite = 1'b1;
               end
               6'b001000: begin
                  w_dec.jump  = 1'b1;
                  w_dec.is_jr = 1'b1;
               end
               6'b001001: begin
                  w_dec.regdst   = 1'b1;
                  w_dec.jump     = 1'b1;
                  w_dec.regwrite = 1'b1;
                  w_dec.link     = 1'b1;
                  w_dec.is_jr    = 1'b1;
               end
               6'b010000, 6'b010010: begin
                  w_dec.regdst   = 1'b1;
                  w_dec.regwrite = 1'b1;
                  w_hazard       = 1'b1;
               end
               6'b010001, 6'b010011: begin
                  w_dec.hilo_write = 1'b1;
                  w_hazard         = 1'b1;
               end
               6'b011000, 6'b011001: begin
                  w_dec.hilo_write   = 1'b1;
                  w_dec.muldiv_start = 1'b1;
                  w_dec.is_mul       = 1'b1;
                  w_hazard           = 1'b1;
               end
               6'b011010, 6'b011011: begin
                  w_dec.hilo_write   = 1'b1;
                  w_dec.muldiv_start = 1'b1;
                  w_dec.is_div       = 1'b1;
                  w_hazard           = 1'b1;
               end
               default: w_dec.illegal = 1'b1;
            endcase
         end
         6'b000001: begin
            case (branchfield)
               5'b00000, 5'b00001: begin
                  w_dec.branch = 1'b1;
                  w_dec.alusrc = 1'b1;
                  w_dec.aluop  = 2'b01;
               end
               5'b10000, 5'b10001: begin
                  w_dec.branch   = 1'b1;
                  w_dec.alusrc   = 1'b1;
                  w_dec.aluop    = 2'b01;
                  w_dec.regwrite = 1'b1;
                  w_dec.link     = 1'b1;
               end
               default: w_dec.illegal = 1'b1;
            endcase
         end
         6'b000010: w_dec.jump = 1'b1;
         6'b000011: begin
            w_dec.jump     = 1'b1;
            w_dec.regwrite = 1'b1;
            w_dec.link     = 1'b1;
         end
         6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
            w_dec.branch = 1'b1;
            w_dec.alusrc = 1'b1;
            w_dec.aluop  = 2'b01;
         end
         6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
            w_dec.regwrite = 1'b1;
            w_dec.alusrc   = 1'b1;
            w_dec.aluop    = 2'b11;
         end
         6'b001010, 6'b001011: begin
            w_dec.regwrite = 1'b1;
            w_dec.alusrc   = 1'b1;
            w_dec.aluop    = 2'b10;
         end
         6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
         6'b100101, 6'b100110: begin
            w_dec.memread  = 1'b1;
            w_dec.memtoreg = 1'b1;
            w_dec.regwrite = 1'b1;
            w_dec.alusrc   = 1'b1;
            w_dec.aluop    = 2'b11;
         end
         6'b101000, 6'b101001, 6'b101011: begin
            w_dec.memwrite = 1'b1;
            w_dec.alusrc   = 1'b1;
            w_dec.aluop    = 2'b11;
         end
         default: w_dec.illegal = 1'b1;
      endcase
   end

   // Next-state logic: one EXEC per instruction, halt after the delay slot.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_FETCH:  if (w_advance) w_next = ST_EXEC;
         ST_EXEC:   w_next = r_halt_pending ? ST_HALTED : ST_FETCH;
         ST_HALTED: w_next = ST_HALTED;
         default:   w_next = ST_FETCH;
      endcase
   end

   // State register; a low clk_enable freezes the sequencer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_FETCH;
      end else if (clk_enable) begin
         r_state <= w_next;
      end
   end

   // Control latch, busy counter and delay-slot / halt bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl           <= '0;
         r_busy_cnt       <= '0;
         r_slot_pending   <= 1'b0;
         r_target_pending <= 1'b0;
         r_halt_pending   <= 1'b0;
      end else if (clk_enable) begin
         if (w_advance) begin
            r_ctrl <= w_dec;
         end

         if (r_state == ST_EXEC && r_ctrl.is_mul) begin
            r_busy_cnt <= c_mult_lat;
         end else if (r_state == ST_EXEC && r_ctrl.is_div) begin
            r_busy_cnt <= c_div_lat;
         end else if (w_busy) begin
            r_busy_cnt <= r_busy_cnt - 1'b1;
         end

         if (r_state == ST_EXEC) begin
            // A branch or jump in a delay slot replaces the old pending pair.
            if (r_ctrl.branch) begin
               r_slot_pending   <= 1'b1;
               r_target_pending <= branch_taken;
            end else if (r_ctrl.jump) begin
               r_slot_pending   <= 1'b1;
               r_target_pending <= 1'b1;
            end else begin
               r_slot_pending   <= 1'b0;
               r_target_pending <= 1'b0;
            end
            if (r_ctrl.is_jr && jr_target_zero) begin
               r_halt_pending <= 1'b1;
            end
         end
      end
   end

   // Output decode from state and latched controls.
   always_comb begin
      regdst        = 1'b0;
      jump          = 1'b0;
      branch        = 1'b0;
      memread       = 1'b0;
      memwrite      = 1'b0;
      memtoreg      = 1'b0;
      regwrite      = 1'b0;
      alusrc        = 1'b0;
      aluop         = 2'b00;
      link          = 1'b0;
      hilo_write    = 1'b0;
      muldiv_start  = 1'b0;
      stall         = 1'b0;
      pc_write      = 1'b0;
      delay_slot    = 1'b0;
      pc_sel_target = 1'b0;
      illegal       = 1'b0;
      active        = !reset && (r_state != ST_HALTED);
      muldiv_busy   = w_busy && (r_state != ST_HALTED);
      case (r_state)
         ST_FETCH: stall = instr_valid && w_hazard && w_busy;
         ST_EXEC: begin
            regdst        = r_ctrl.regdst;
            jump          = r_ctrl.jump;
            branch        = r_ctrl.branch;
            memread       = r_ctrl.memread;
            memwrite      = r_ctrl.memwrite;
            memtoreg      = r_ctrl.memtoreg;
            regwrite      = r_ctrl.regwrite;
            alusrc        = r_ctrl.alusrc;
            aluop         = r_ctrl.aluop;
            link          = r_ctrl.link;
            hilo_write    = r_ctrl.hilo_write;
            muldiv_start  = r_ctrl.muldiv_start;
            illegal       = r_ctrl.illegal;
            pc_write      = 1'b1;
            delay_slot    = r_slot_pending;
            pc_sel_target = r_slot_pending && r_target_pending;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_ctrl_seq
//  Purpose  : Directed self-checking bench for mips_ctrl_seq.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_ctrl_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       clk_enable;
   logic       instr_valid;
   logic [5:0] insop;
   logic [4:0] branchfield;
   logic [5:0] func;
   logic       branch_taken;
   logic       jr_target_zero;
   logic       regdst, jump, branch, memread, memwrite, memtoreg, regwrite, alusrc;
   logic [1:0] aluop;
   logic       link, hilo_write, muldiv_start, muldiv_busy, stall, pc_write;
   logic       delay_slot, pc_sel_target, illegal, active;

   int n_vec = 0;
   int n_err = 0;

   // Output bit masks for the packed observation word.
   localparam logic [19:0] K_RD    = 20'h1 << 19;
   localparam logic [19:0] K_J     = 20'h1 << 18;
   localparam logic [19:0] K_BR    = 20'h1 << 17;
   localparam logic [19:0] K_MR    = 20'h1 << 16;
   localparam logic [19:0] K_MW    = 20'h1 << 15;
   localparam logic [19:0] K_MTR   = 20'h1 << 14;
   localparam logic [19:0] K_RW    = 20'h1 << 13;
   localparam logic [19:0] K_AS    = 20'h1 << 12;
   localparam logic [19:0] K_ALU11 = 20'h3 << 10;
   localparam logic [19:0] K_ALU10 = 20'h2 << 10;
   localparam logic [19:0] K_ALU01 = 20'h1 << 10;
   localparam logic [19:0] K_LNK   = 20'h1 << 9;
   localparam logic [19:0] K_HW    = 20'h1 << 8;
   localparam logic [19:0] K_MDS   = 20'h1 << 7;
   localparam logic [19:0] K_BUSY  = 20'h1 << 6;
   localparam logic [19:0] K_STALL = 20'h1 << 5;
   localparam logic [19:0] K_PCW   = 20'h1 << 4;
   localparam logic [19:0] K_DS    = 20'h1 << 3;
   localparam logic [19:0] K_PST   = 20'h1 << 2;
   localparam logic [19:0] K_ILL   = 20'h1 << 1;
   localparam logic [19:0] K_ACT   = 20'h1;

   localparam logic [19:0] E_IMM   = K_RW | K_AS | K_ALU11 | K_PCW | K_ACT;
   localparam logic [19:0] E_BR    = K_BR | K_AS | K_ALU01 | K_PCW | K_ACT;

   logic [19:0] obs;
   assign obs = {regdst, jump, branch, memread, memwrite, memtoreg, regwrite,
                 alusrc, aluop, link, hilo_write, muldiv_start, muldiv_busy,
                 stall, pc_write, delay_slot, pc_sel_target, illegal, active};

   mips_ctrl_seq #(.MULT_LAT(4), .DIV_LAT(34), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable),
      .instr_valid(instr_valid), .insop(insop), .branchfield(branchfield),
      .func(func), .branch_taken(branch_taken), .jr_target_zero(jr_target_zero),
      .regdst(regdst), .jump(jump), .branch(branch), .memread(memread),
      .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite),
      .alusrc(alusrc), .aluop(aluop), .link(link), .hilo_write(hilo_write),
      .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy), .stall(stall),
      .pc_write(pc_write), .delay_slot(delay_slot),
      .pc_sel_target(pc_sel_target), .illegal(illegal), .active(active)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [19:0] exp);
      #1;
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [5:0] op, input logic [4:0] rt, input logic [5:0] fn);
      insop       = op;
      branchfield = rt;
      func        = fn;
      instr_valid = 1'b1;
   endtask

   // Called in FETCH; checks the EXEC cycle and returns in the next FETCH.
   task automatic exec_instr(input logic [5:0] op, input logic [4:0] rt,
                             input logic [5:0] fn, input logic bt, input logic jz,
                             input string tag, input logic [19:0] exp);
      issue(op, rt, fn);
      branch_taken   = bt;
      jr_target_zero = jz;
      cyc();
      instr_valid = 1'b0;
      chk(tag, exp);
      cyc();
   endtask

   initial begin
      reset = 1'b1; clk_enable = 1'b1; instr_valid = 1'b0;
      insop = '0; branchfield = '0; func = '0;
      branch_taken = 1'b0; jr_target_zero = 1'b0;
      cyc(); cyc();
      chk("reset_hold", 20'h0);
      reset = 1'b0;
      chk("reset_release", K_ACT);

      // ADDIU: FETCH, EXEC, back to FETCH
      issue(6'b001001, 5'd0, 6'd0);
      chk("addiu_fetch", K_ACT);
      cyc();
      instr_valid = 1'b0;
      chk("addiu_exec", E_IMM);
      cyc();
      chk("addiu_refetch", K_ACT);

      // Decode classes
      exec_instr(6'b111111, 5'd0, 6'd0, 1'b0, 1'b0, "illegal_op", K_ILL | K_PCW | K_ACT);
      chk("illegal_after", K_ACT);
      exec_instr(6'b000000, 5'd0, 6'b100000, 1'b0, 1'b0, "illegal_func", K_ILL | K_PCW | K_ACT);
      exec_instr(6'b000001, 5'b00111, 6'd0, 1'b0, 1'b0, "illegal_rt", K_ILL | K_PCW | K_ACT);
      exec_instr(6'b100011, 5'd0, 6'd0, 1'b0, 1'b0, "lw", K_MR | K_MTR | E_IMM);
      exec_instr(6'b101011, 5'd0, 6'd0, 1'b0, 1'b0, "sw", K_MW | K_AS | K_ALU11 | K_PCW | K_ACT);
      exec_instr(6'b001010, 5'd0, 6'd0, 1'b0, 1'b0, "slti", K_RW | K_AS | K_ALU10 | K_PCW | K_ACT);
      exec_instr(6'b000000, 5'd0, 6'b100001, 1'b0, 1'b0, "addu", K_RD | K_RW | K_PCW | K_ACT);
      exec_instr(6'b000000, 5'd0, 6'b010001, 1'b0, 1'b0, "mthi", K_HW | K_PCW | K_ACT);
      exec_instr(6'b000011, 5'd0, 6'd0, 1'b0, 1'b0, "jal", K_J | K_RW | K_LNK | K_PCW | K_ACT);
      exec_instr(6'b000000, 5'd0, 6'b000000, 1'b0, 1'b0, "jal_slot", K_RD | K_RW | K_PCW | K_DS | K_PST | K_ACT);

      // clk_enable low freezes EXEC
      issue(6'b001101, 5'd0, 6'd0);
      cyc();
      instr_valid = 1'b0;
      chk("ori_exec", E_IMM);
      clk_enable = 1'b0;
      cyc();
      chk("freeze_hold", E_IMM);
      clk_enable = 1'b1;
      cyc();
      chk("freeze_release", K_ACT);

      // MULT then MFLO: four stall cycles
      exec_instr(6'b000000, 5'd0, 6'b011000, 1'b0, 1'b0, "mult_exec", K_HW | K_MDS | K_PCW | K_ACT);
      issue(6'b000000, 5'd0, 6'b010010);
      for (int i = 0; i < 4; i++) begin
         if (i != 0) cyc();
         chk("mflo_stall", K_STALL | K_BUSY | K_ACT);
      end
      cyc();
      chk("mflo_unstall", K_ACT);
      cyc();
      instr_valid = 1'b0;
      chk("mflo_exec", K_RD | K_RW | K_PCW | K_ACT);
      cyc();

      // Branch taken / not taken with delay slot
      exec_instr(6'b000100, 5'd0, 6'd0, 1'b1, 1'b0, "beq_t", E_BR);
      exec_instr(6'b001001, 5'd0, 6'd0, 1'b0, 1'b0, "slot_taken", E_IMM | K_DS | K_PST);
      exec_instr(6'b001001, 5'd0, 6'd0, 1'b0, 1'b0, "after_slot", E_IMM);
      exec_instr(6'b000100, 5'd0, 6'd0, 1'b0, 1'b0, "beq_nt", E_BR);
      exec_instr(6'b001001, 5'd0, 6'd0, 1'b0, 1'b0, "slot_not_taken", E_IMM | K_DS);
      exec_instr(6'b000001, 5'b10000, 6'd0, 1'b1, 1'b0, "bltzal", E_BR | K_RW | K_LNK);
      exec_instr(6'b100011, 5'd0, 6'd0, 1'b0, 1'b0, "bltzal_slot", K_MR | K_MTR | E_IMM | K_DS | K_PST);

      // JALR to nonzero target does not halt
      exec_instr(6'b000000, 5'd0, 6'b001001, 1'b0, 1'b0, "jalr", K_RD | K_J | K_RW | K_LNK | K_PCW | K_ACT);
      exec_instr(6'b101011, 5'd0, 6'd0, 1'b0, 1'b0, "jalr_slot", K_MW | K_AS | K_ALU11 | K_PCW | K_DS | K_PST | K_ACT);
      chk("no_halt", K_ACT);

      // JR to zero: slot executes, then halt
      exec_instr(6'b000000, 5'd0, 6'b001000, 1'b0, 1'b1, "jr_zero", K_J | K_PCW | K_ACT);
      jr_target_zero = 1'b0;
      exec_instr(6'b001001, 5'd0, 6'd0, 1'b0, 1'b0, "halt_slot", E_IMM | K_DS | K_PST);
      chk("halted", 20'h0);
      issue(6'b001001, 5'd0, 6'd0);
      cyc();
      chk("halted_ignore1", 20'h0);
      cyc();
      chk("halted_ignore2", 20'h0);
      instr_valid = 1'b0;

      // Reset leaves HALTED
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("unhalt_reset", K_ACT);

      // DIV then MTLO stalled; reset mid-stall discards busy count
      exec_instr(6'b000000, 5'd0, 6'b011010, 1'b0, 1'b0, "div_exec", K_HW | K_MDS | K_PCW | K_ACT);
      issue(6'b000000, 5'd0, 6'b010011);
      chk("mtlo_stall", K_STALL | K_BUSY | K_ACT);
      reset = 1'b1;
      chk("reset_mid_stall", 20'h0);
      cyc();
      reset = 1'b0;
      instr_valid = 1'b0;
      chk("after_stall_reset", K_ACT);

      // Reset asserted mid-EXEC of DIV
      issue(6'b000000, 5'd0, 6'b011011);
      cyc();
      instr_valid = 1'b0;
      chk("divu_exec", K_HW | K_MDS | K_PCW | K_ACT);
      reset = 1'b1;
      chk("reset_mid_exec", 20'h0);
      cyc();
      reset = 1'b0;
      chk("after_exec_reset", K_ACT);
      issue(6'b000000, 5'd0, 6'b010000);
      chk("mfhi_no_stall", K_ACT);
      cyc();
      instr_valid = 1'b0;
      chk("mfhi_exec", K_RD | K_RW | K_PCW | K_ACT);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mips_ctrl_seq.md
Name: mips_ctrl_seq

Overview:
Sequential successor to the combinational MIPS main decoder. It decodes opcode, REGIMM branch field and function field exactly as before, and sequences each instruction through FETCH and EXEC states. It adds a background multiply/divide busy counter with parametrised latency, HI/LO hazard stalls, branch-delay-slot tracking and halt-on-jump-to-zero. It sits between instruction memory and the datapath of the Harvard CPU.

Parameters:
MULT_LAT, 4, cycles MULT/MULTU keeps HI/LO busy (>=1)
DIV_LAT, 34, cycles DIV/DIVU keeps HI/LO busy (>=1)
CNT_W, 6, busy counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
clk_enable  in  1  global advance enable; low freezes all state
instr_valid  in  1  instruction word fields are valid this cycle
insop  in  6  opcode [31:26]
branchfield  in  5  rt field [20:16] (REGIMM decode)
func  in  6  function [5:0]
branch_taken  in  1  comparator result, sampled in EXEC of a branch
jr_target_zero  in  1  JR/JALR target == 0, sampled in EXEC
regdst, jump, branch, memread, memwrite, memtoreg, regwrite, alusrc  out  1 each  datapath controls
aluop  out  2  ALU class
link  out  1  write PC+8 to link register
hilo_write  out  1  MULT/DIV/MTHI/MTLO commits HI/LO
muldiv_start  out  1  one-cycle start pulse to mul/div unit
muldiv_busy  out  1  busy counter != 0
stall  out  1  FETCH held by HI/LO hazard
pc_write  out  1  advance PC
delay_slot  out  1  current EXEC instruction is a delay slot
pc_sel_target  out  1  PC <- latched branch/jump target this cycle
illegal  out  1  undecodable instruction (one-cycle pulse)
active  out  1  CPU running

Behaviour:
- Reset (async): state=FETCH, busy counter=0, pending flags clear; every output 0 except active=1 once reset deasserts.
- clk_enable=0: no state, counter or flag changes; outputs hold.
- FETCH: all controls 0. Advance to EXEC when instr_valid && clk_enable && !(hazard && muldiv_busy). Hazard = instruction is MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU. stall=1 while blocked only by the hazard. Decoded controls are registered on the advancing edge.
- EXEC (one cycle): registered controls drive the outputs; pc_write=1. Then return to FETCH, or go to HALTED if halt_pending.
- Decode classes (controls not listed are 0):
  - R-ALU (ADDU, AND, OR, XOR, SUBU, SLT, SLTU, shifts): regdst, regwrite, aluop=00.
  - MFHI/MFLO: regdst, regwrite.
  - MTHI/MTLO: hilo_write.
  - MULT/MULTU/DIV/DIVU: hilo_write and muldiv_start; busy counter loads MULT_LAT or DIV_LAT.
  - JR: jump. JALR: regdst, jump, regwrite, link.
  - ADDIU/ANDI/ORI/XORI/LUI: regwrite, alusrc, aluop=11. SLTI/SLTIU: same with aluop=10.
  - Loads (LB, LH, LWL, LW, LBU, LHU, LWR): memread, memtoreg, regwrite, alusrc, aluop=11.
  - Stores (SB, SH, SW): memwrite, alusrc, aluop=11.
  - BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ: branch, alusrc, aluop=01. BLTZAL/BGEZAL: same plus regwrite, link.
  - J: jump. JAL: jump, regwrite, link.
  - Any other opcode, func or REGIMM rt: all controls 0, illegal=1 during EXEC, treated as NOP.
- Busy counter: loaded in a MULT/DIV EXEC cycle; decrements by 1 each enabled cycle while nonzero, saturating at 0. A new load overrides the old value.
- Delay slot:
  - EXEC of a branch latches target_pending = branch_taken. EXEC of a jump latches target_pending = 1.
  - slot_pending=1 is set after any branch or jump EXEC.
  - In the next EXEC: delay_slot=1, pc_sel_target=target_pending, then both flags clear.
  - A branch inside a delay slot is executed, but its own pending flags overwrite the old ones (undefined in ISA; documented here).
- Halt:
  - JR/JALR with jr_target_zero=1 sets halt_pending.
  - The delay-slot instruction executes; after its EXEC, go to HALTED.
  - In HALTED: active=0 and all outputs 0; only reset leaves HALTED.
- Reset mid-EXEC or mid-stall: immediate return to reset values; an in-flight busy count is discarded.

Test Plan:
1. ADDIU (insop=001001) with instr_valid=1 at cycle 1 -> cycle 2: regwrite=1, alusrc=1, aluop=11, pc_write=1; cycle 3: all controls 0 (FETCH).
2. MULT (func=011000) EXEC at cycle t, MFLO valid at t+1, MULT_LAT=4 -> muldiv_start=1 at t; stall=1 at t+1..t+4; MFLO EXEC at t+6 with regdst=1, regwrite=1.
3. BEQ with branch_taken=1, then ADDIU -> ADDIU EXEC has delay_slot=1, pc_sel_target=1; next EXEC has both 0. Repeat with branch_taken=0 -> pc_sel_target=0, delay_slot=1.
4. JR with jr_target_zero=1, then ADDIU -> ADDIU EXEC occurs with pc_write=1; the following cycle active=0, and instr_valid is then ignored.
5. insop=111111 -> illegal=1 for one EXEC cycle, all other controls 0, pc_write=1.
6. reset asserted mid-EXEC of DIV -> outputs 0 asynchronously, muldiv_busy=0; after release active=1, state FETCH.
